// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: default widths, NOP word, loader states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package inst_rom_loader_pkg;

    localparam int DEF_INST_ADDR_WIDTH = 32;
    localparam int DEF_INST_DATA_WIDTH = 32;
    localparam int DEF_DEPTH_LOG2      = 10;

    // Instruction returned whenever the core must not see real program data
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } load_state_t;

    // Drop one byte into its big-endian lane of a partially assembled word
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [7:0]  data,
                                               input logic [1:0]  idx);
        logic [31:0] merged;
        merged = word;
        case (idx)
            2'd0:    merged[31:24] = data;
            2'd1:    merged[23:16] = data;
            2'd2:    merged[15:8]  = data;
            default: merged[7:0]   = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction word array: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge, read is zero-cycle.
// Backpressure: none; caller guarantees write/read ordering.
module inst_mem_1w1r #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    // Write port; the array is deliberately never cleared so old program words survive reloads
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core fetch port, filled by a byte-stream loader that holds the core in reset.
// Latency: fetch is combinational (zero cycles); a loaded word is written on the edge accepting its final byte.
// Backpressure: load_byte_ready is high only while loading; bytes are refused in IDLE/RUN.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int INST_DATA_WIDTH = DEF_INST_DATA_WIDTH,
    parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INST_ADDR_WIDTH-1:0] rom_addr_in,
    input  logic                       rom_enable_in,
    output logic [INST_DATA_WIDTH-1:0] rom_data_out,
    input  logic                       load_start,
    input  logic [7:0]                 load_byte,
    input  logic                       load_byte_valid,
    input  logic                       load_byte_last,
    output logic                       load_byte_ready,
    output logic [DEPTH_LOG2:0]        load_word_count,
    output logic                       load_done,
    output logic                       load_err,
    output logic                       cpu_rst_n_out
);

    load_state_t            r_state;
    logic [DEPTH_LOG2:0]    r_ptr;        // next word index; doubles as words-written count
    logic [1:0]             r_byte_idx;
    logic [31:0]            r_asm;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_err;
    logic                   r_cpu_rst_n;

    logic                   w_accept;
    logic                   w_word_end;
    logic                   w_last_slot;
    logic [31:0]            w_word;
    logic [INST_DATA_WIDTH-1:0] w_rdata;
    logic                   w_addr_in_range;
    logic                   w_fetch_ok;
    logic                   w_unused_addr_lsb;

    // load_start outranks a byte on the same edge, and a byte seen during reset is ignored
    assign w_accept    = rst_n & ~load_start & load_byte_valid & r_ready;
    assign w_word_end  = w_accept & (load_byte_last | (r_byte_idx == 2'd3));
    assign w_last_slot = &r_ptr[DEPTH_LOG2-1:0];
    // Lanes not yet received are still zero in r_asm, which gives the short-word padding for free
    assign w_word      = merge_byte(r_asm, load_byte, r_byte_idx);

    // Loader FSM: restart on load_start, assemble bytes, commit words, enter RUN on last/overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 32'h0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else if (load_start) begin
            r_state     <= ST_LOAD;
            r_ptr       <= '0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 32'h0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_word_end) begin
                            r_ptr      <= r_ptr + 1'b1;
                            r_byte_idx <= 2'd0;
                            r_asm      <= 32'h0;
                            // Finish on the last byte, or when the top word is filled (never wrap to 0)
                            if (load_byte_last || w_last_slot) begin
                                r_state     <= ST_RUN;
                                r_ready     <= 1'b0;
                                r_done      <= 1'b1;
                                r_cpu_rst_n <= 1'b1;
                                if (!load_byte_last || (r_byte_idx != 2'd3)) begin
                                    r_err <= 1'b1;
                                end
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_asm      <= w_word;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    inst_mem_1w1r #(
        .DATA_W     (INST_DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_word_end),
        .i_waddr (r_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (w_word),
        .i_raddr (rom_addr_in[DEPTH_LOG2+1:2]),
        .o_rdata (w_rdata)
    );

    // Byte offset within a word is irrelevant to word fetches
    assign w_unused_addr_lsb = ^rom_addr_in[1:0];
    assign w_addr_in_range   = ((rom_addr_in >> (DEPTH_LOG2 + 2)) == '0);
    // Only RUN exposes memory, so a fetch can never collide with a loader write
    assign w_fetch_ok        = (r_state == ST_RUN) & rom_enable_in & w_addr_in_range;
    assign rom_data_out      = w_fetch_ok ? w_rdata : NOP_WORD;

    assign load_byte_ready = r_ready;
    assign load_word_count = r_ptr;
    assign load_done       = r_done;
    assign load_err        = r_err;
    assign cpu_rst_n_out   = r_cpu_rst_n;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two instances (1024-word and 4-word) share one stimulus stream.
// Expected values come from a byte-list model and are queued; a negedge monitor pops and compares.
module tb_inst_rom_loader;

    localparam int DL0 = 10;
    localparam int DL1 = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] rom_addr_in;
    logic        rom_enable_in;
    logic        load_start;
    logic [7:0]  load_byte;
    logic        load_byte_valid;
    logic        load_byte_last;

    logic [31:0] data0, data1;
    logic [DL0:0] cnt0;
    logic [DL1:0] cnt1;
    logic        rdy0, rdy1, done0, done1, err0, err1, cpu0, cpu1;

    inst_rom_loader #(.INST_ADDR_WIDTH(32), .INST_DATA_WIDTH(32), .DEPTH_LOG2(DL0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rom_addr_in(rom_addr_in), .rom_enable_in(rom_enable_in),
        .rom_data_out(data0), .load_start(load_start), .load_byte(load_byte),
        .load_byte_valid(load_byte_valid), .load_byte_last(load_byte_last),
        .load_byte_ready(rdy0), .load_word_count(cnt0), .load_done(done0),
        .load_err(err0), .cpu_rst_n_out(cpu0)
    );

    inst_rom_loader #(.INST_ADDR_WIDTH(32), .INST_DATA_WIDTH(32), .DEPTH_LOG2(DL1)) u_small (
        .clk(clk), .rst_n(rst_n), .rom_addr_in(rom_addr_in), .rom_enable_in(rom_enable_in),
        .rom_data_out(data1), .load_start(load_start), .load_byte(load_byte),
        .load_byte_valid(load_byte_valid), .load_byte_last(load_byte_last),
        .load_byte_ready(rdy1), .load_word_count(cnt1), .load_done(done1),
        .load_err(err1), .cpu_rst_n_out(cpu1)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int          dut;
        int          kind;   // 0 data, 1 count, 2 ready, 3 done, 4 err, 5 cpu_rst_n
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   finished = 1'b0;

    function automatic string kname(input int k);
        case (k)
            0: return "rom_data_out";
            1: return "load_word_count";
            2: return "load_byte_ready";
            3: return "load_done";
            4: return "load_err";
            default: return "cpu_rst_n_out";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int d, input int k);
        case (k)
            0: return (d == 0) ? data0 : data1;
            1: return (d == 0) ? 32'(cnt0) : 32'(cnt1);
            2: return (d == 0) ? 32'(rdy0) : 32'(rdy1);
            3: return (d == 0) ? 32'(done0) : 32'(done1);
            4: return (d == 0) ? 32'(err0) : 32'(err1);
            default: return (d == 0) ? 32'(cpu0) : 32'(cpu1);
        endcase
    endfunction

    // Direct comparison used for the reset-state checks
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic chk_reset_state();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("reset dut%0d %s", d, kname(k)), actual(d, k), 32'h0);
            end
        end
    endtask

    // Monitor: everything queued for this cycle is compared mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb_q.pop_front();
            a = actual(e.dut, e.kind);
            n_vec++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s dut%0d @%0t: got %h, expected %h", kname(e.kind), e.dut, $time, a, e.val);
            end
        end
    end

    // Watchdog: the stimulus must finish before the wait expires
    initial begin
        #2_000_000;
        if (!finished) begin
            n_err++;
            $display("FAIL timeout @%0t: stimulus did not complete", $time);
            $finish;
        end
    end

    // ---------------- reference model ----------------
    int          m_st  [2];   // 0 idle, 1 loading, 2 running
    int          m_n   [2];   // bytes accepted in current load
    int          m_cnt [2];
    bit          m_err [2];
    logic [7:0]  m_buf [2][4096];
    logic [31:0] m_mem [2][1024];
    bit          m_vld [2][1024];

    function automatic int dlog(input int d);
        return (d == 0) ? DL0 : DL1;
    endfunction

    // Turn the accepted byte list into words; partial trailing word only when padded
    task automatic commit(input int d, input bit pad);
        int nw;
        nw = pad ? (m_n[d] + 3) / 4 : m_n[d] / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] v;
            v = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < m_n[d]) v[31 - 8 * b -: 8] = m_buf[d][4 * w + b];
            end
            m_mem[d][w] = v;
            m_vld[d][w] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int depth;
            depth = 1 << dlog(d);
            if (!rst_n) begin
                if (m_st[d] == 1) commit(d, 1'b0);
                m_st[d] = 0; m_err[d] = 1'b0; m_cnt[d] = 0;
            end else if (load_start) begin
                if (m_st[d] == 1) commit(d, 1'b0);
                m_st[d] = 1; m_n[d] = 0; m_err[d] = 1'b0; m_cnt[d] = 0;
            end else if (m_st[d] == 1 && load_byte_valid) begin
                m_buf[d][m_n[d]] = load_byte;
                m_n[d]++;
                if (load_byte_last) begin
                    commit(d, 1'b1);
                    m_cnt[d] = (m_n[d] + 3) / 4;
                    m_err[d] = (m_n[d] % 4) != 0;
                    m_st[d]  = 2;
                end else if (m_n[d] == 4 * depth) begin
                    commit(d, 1'b0);
                    m_cnt[d] = depth;
                    m_err[d] = 1'b1;
                    m_st[d]  = 2;
                end else begin
                    m_cnt[d] = m_n[d] / 4;
                end
            end
        end
    endtask

    task automatic push_checks();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.dut = d;
            e.kind = 1; e.val = 32'(m_cnt[d]);            sb_q.push_back(e);
            e.kind = 2; e.val = 32'(m_st[d] == 1);        sb_q.push_back(e);
            e.kind = 3; e.val = 32'(m_st[d] == 2);        sb_q.push_back(e);
            e.kind = 4; e.val = 32'(m_err[d]);            sb_q.push_back(e);
            e.kind = 5; e.val = 32'(m_st[d] == 2);        sb_q.push_back(e);
            e.kind = 0;
            if (m_st[d] == 2 && rom_enable_in && ((rom_addr_in >> (dlog(d) + 2)) == 0)) begin
                int idx;
                idx = int'(rom_addr_in >> 2) & ((1 << dlog(d)) - 1);
                if (m_vld[d][idx]) begin
                    e.val = m_mem[d][idx];
                    sb_q.push_back(e);
                end
            end else begin
                e.val = 32'h0;
                sb_q.push_back(e);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc();
        push_checks();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_byte_valid = 1'b1; load_byte = b; load_byte_last = last;
        cyc();
        load_byte_valid = 1'b0; load_byte_last = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic en);
        rom_addr_in = addr; rom_enable_in = en;
        cyc();
    endtask

    task automatic start_pulse();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic rnd_idle();
        logic [31:0] a;
        a = ($urandom_range(0, 7) == 0) ? (32'h1000 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 127));
        load_byte_valid = 1'b0;
        load_byte = 8'($urandom);
        fetch(a, $urandom_range(0, 3) != 0);
    endtask

    logic [7:0] prog8 [8];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_n[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0;
            for (int i = 0; i < 1024; i++) m_vld[d][i] = 1'b0;
        end
        rst_n = 1'b0; rom_addr_in = 32'h0; rom_enable_in = 1'b1;
        load_start = 1'b0; load_byte = 8'h0; load_byte_valid = 1'b0; load_byte_last = 1'b0;
        @(posedge clk); model_edge(); #1;
        chk_reset_state();
        cyc();                              // reset values
        rst_n = 1'b1;
        cyc();

        // Two-word program, last on 8th byte
        prog8 = '{8'h34, 8'h02, 8'h00, 8'h20, 8'h34, 8'h03, 8'h00, 8'h10};
        start_pulse();
        for (int i = 0; i < 8; i++) send_byte(prog8[i], i == 7);
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h6, 1'b1);
        fetch(32'h4, 1'b0);                 // disabled -> NOP
        fetch(32'h0000_1000, 1'b1);         // out of range -> NOP

        // Short final word
        prog8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h00, 8'h00};
        start_pulse();
        for (int i = 0; i < 6; i++) send_byte(prog8[i], i == 5);
        fetch(32'h4, 1'b1);
        fetch(32'h0, 1'b1);
        // Restart from RUN: core back in reset, fetch forced to NOP
        start_pulse();
        fetch(32'h0, 1'b1);

        // 16 bytes without last: small instance overflows; 17th carries last
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 6; i++) fetch(32'(4 * i), 1'b1);

        // load_start with a byte on the same edge drops the byte
        load_start = 1'b1; load_byte_valid = 1'b1; load_byte = 8'hEE;
        cyc();
        load_start = 1'b0; load_byte_valid = 1'b0;
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b1);
        fetch(32'h0, 1'b1);
        fetch(32'h3, 1'b1);

        // Reset in the middle of a load, then a shorter reload
        start_pulse();
        for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i), 1'b0);
        rst_n = 1'b0;
        cyc();
        chk_reset_state();
        rst_n = 1'b1;
        fetch(32'h4, 1'b1);
        start_pulse();
        send_byte(8'hC0, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'hEE, 1'b0); send_byte(8'h01, 1'b1);
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);                 // word from the aborted load survives

        // Randomized loads with gaps, optional last, restarts mid-load
        for (int it = 0; it < 30; it++) begin
            int len;
            bit with_last;
            len = $urandom_range(1, 22);
            with_last = ($urandom_range(0, 3) != 0);
            start_pulse();
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) rnd_idle();
                send_byte(8'($urandom), with_last && (i == len - 1));
            end
            for (int k = 0; k < 6; k++) rnd_idle();
        end

        load_byte_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        finished = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
